// File: rtl/rx_frame_capture.sv
// UART Rx frame capture: deserializes bits flagged by the Rx FSM, checks parity and stop,
// and queues finished frames in a small FIFO with a valid/ready head and a sticky overrun flag.
module rx_frame_capture #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 serial_in,
  input  logic                 sampling_strobe,
  input  logic                 data_is_available,
  input  logic                 is_parity_stage,
  input  logic                 data_is_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_overrun,
  input  logic                 clear_overrun
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int BCW  = $clog2(DATA_BITS + 1);
  localparam int EW   = DATA_BITS + 2;

  typedef logic [EW-1:0] entry_t;

  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic                 extra_q, extra_d;
  logic                 par_bit_q, par_bit_d;
  logic                 par_seen_q, par_seen_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 overrun_q, overrun_d;
  entry_t               mem_q [FIFO_DEPTH];
  entry_t               mem_d [FIFO_DEPTH];

  logic                 take_data, take_par, take_stop;
  logic                 full, pop, push_ok, drop;
  logic                 frame_err_w, parity_err_w;
  logic [DATA_BITS:0]   shift_w;
  entry_t               head;

  assign take_data = sampling_strobe & data_is_available;
  assign take_par  = sampling_strobe & is_parity_stage;
  assign take_stop = sampling_strobe & data_is_valid;
  assign shift_w   = {serial_in, shreg_q};

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign pop     = rx_valid & rx_ready;
  // A push into a full FIFO still lands when the same edge pops the head.
  assign push_ok = take_stop & (~full | pop);
  assign drop    = take_stop & full & ~pop;

  assign frame_err_w  = ~serial_in | (bit_cnt_q != BCW'(DATA_BITS)) | extra_q;
  assign parity_err_w = (PARITY_EN != 0) &
                        (~par_seen_q | ((^shreg_q) ^ par_bit_q ^ (PARITY_ODD != 0)));

  always_comb begin
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    extra_d    = extra_q;
    par_bit_d  = par_bit_q;
    par_seen_d = par_seen_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    mem_d      = mem_q;

    if (take_data) begin
      shreg_d = shift_w[DATA_BITS:1];
      if (bit_cnt_q == BCW'(DATA_BITS)) extra_d = 1'b1;
      else                              bit_cnt_d = BCW'(bit_cnt_q + BCW'(1));
    end

    if (take_par) begin
      par_bit_d  = serial_in;
      par_seen_d = 1'b1;
    end

    if (take_stop) begin
      shreg_d    = '0;
      bit_cnt_d  = '0;
      extra_d    = 1'b0;
      par_bit_d  = 1'b0;
      par_seen_d = 1'b0;
    end

    if (push_ok) begin
      mem_d[wr_ptr_q] = {parity_err_w, frame_err_w, shreg_q};
      wr_ptr_d        = AW'(wr_ptr_q + AW'(1));
    end
    if (pop) rd_ptr_d = AW'(rd_ptr_q + AW'(1));

    case ({push_ok, pop})
      2'b10:   count_d = CW'(count_q + CW'(1));
      2'b01:   count_d = CW'(count_q - CW'(1));
      default: count_d = count_q;
    endcase

    if (drop)               overrun_d = 1'b1;
    else if (clear_overrun) overrun_d = 1'b0;
    else                    overrun_d = overrun_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      extra_q    <= 1'b0;
      par_bit_q  <= 1'b0;
      par_seen_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
    end else begin
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      extra_q    <= extra_d;
      par_bit_q  <= par_bit_d;
      par_seen_q <= par_seen_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overrun_q  <= overrun_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head          = mem_q[rd_ptr_q];
  assign rx_valid      = (count_q != '0);
  assign rx_data       = rx_valid ? head[DATA_BITS-1:0] : '0;
  assign rx_frame_err  = rx_valid & head[DATA_BITS];
  assign rx_parity_err = rx_valid & head[DATA_BITS+1];
  assign rx_overrun    = overrun_q;

endmodule

// File: tb/tb_rx_frame_capture.sv
// Bench for rx_frame_capture: table-driven frames, hand sequences for FIFO/overrun/reset
// corners, and a randomized run checked against a queue-based reference model.
module tb_rx_frame_capture;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       serial_in = 1'b0;
  logic       sampling_strobe = 1'b0;
  logic       data_is_available = 1'b0;
  logic       is_parity_stage = 1'b0;
  logic       data_is_valid = 1'b0;
  logic       rx_ready = 1'b0;
  logic       clear_overrun = 1'b0;
  logic [7:0] rx_data, rx_data2;
  logic       rx_parity_err, rx_frame_err, rx_valid, rx_overrun;
  logic       rx_parity_err2, rx_frame_err2, rx_valid2, rx_overrun2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  rx_frame_capture #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .serial_in(serial_in), .sampling_strobe(sampling_strobe),
    .data_is_available(data_is_available), .is_parity_stage(is_parity_stage),
    .data_is_valid(data_is_valid), .rx_data(rx_data), .rx_parity_err(rx_parity_err),
    .rx_frame_err(rx_frame_err), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_overrun(rx_overrun), .clear_overrun(clear_overrun));

  rx_frame_capture #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .FIFO_DEPTH(4)) dut_np (
    .clk(clk), .reset(reset), .serial_in(serial_in), .sampling_strobe(sampling_strobe),
    .data_is_available(data_is_available), .is_parity_stage(is_parity_stage),
    .data_is_valid(data_is_valid), .rx_data(rx_data2), .rx_parity_err(rx_parity_err2),
    .rx_frame_err(rx_frame_err2), .rx_valid(rx_valid2), .rx_ready(rx_ready),
    .rx_overrun(rx_overrun2), .clear_overrun(clear_overrun));

  // Reference model: queue of {parity_err, frame_err, data}, received bits kept as a list.
  logic [9:0] mq[$];
  bit         rbits[$];
  bit         m_ovr, m_pseen, m_pbit;
  bit         rand_ctl = 1'b0;
  bit         chk_each = 1'b0;

  function automatic logic [9:0] model_frame(input bit stop);
    int n, m;
    logic [7:0] d;
    logic pe, fe;
    n = rbits.size();
    m = (n < 8) ? n : 8;
    d = '0;
    for (int j = 0; j < m; j++) d[8 - m + j] = rbits[n - m + j];
    fe = !stop || (n != 8);
    pe = !m_pseen || ((^d) ^ m_pbit);
    return {pe, fe, d};
  endfunction

  task automatic model_edge();
    bit pop, push, drop;
    logic [9:0] e;
    pop = 0; push = 0; drop = 0; e = '0;
    if (!reset) begin
      mq.delete(); rbits.delete(); m_ovr = 0; m_pseen = 0; m_pbit = 0;
      return;
    end
    pop = rx_ready && (mq.size() > 0);
    if (sampling_strobe && data_is_available) rbits.push_back(serial_in);
    else if (sampling_strobe && is_parity_stage) begin
      m_pseen = 1; m_pbit = serial_in;
    end else if (sampling_strobe && data_is_valid) begin
      e = model_frame(serial_in);
      rbits.delete(); m_pseen = 0; m_pbit = 0;
      if (mq.size() == 4 && !pop) drop = 1;
      else push = 1;
    end
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(e);
    m_ovr = drop ? 1'b1 : (clear_overrun ? 1'b0 : m_ovr);
  endtask

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string name);
    logic v;
    logic [9:0] h;
    v = (mq.size() != 0);
    h = v ? mq[0] : 10'd0;
    cmp({name, "_p"}, {4'd0, v, h[9], h[8], h[7:0], m_ovr},
        {4'd0, rx_valid, rx_parity_err, rx_frame_err, rx_data, rx_overrun});
    cmp({name, "_np"}, {4'd0, v, 1'b0, h[8], h[7:0], m_ovr},
        {4'd0, rx_valid2, rx_parity_err2, rx_frame_err2, rx_data2, rx_overrun2});
  endtask

  task automatic step();
    if (rand_ctl) begin
      rx_ready = ($urandom_range(0, 3) == 0);
      clear_overrun = ($urandom_range(0, 15) == 0);
    end
    model_edge();
    @(posedge clk);
    #1;
    if (chk_each) check_all("rand");
  endtask

  task automatic strobe_bit(input bit dav, input bit par, input bit stp, input bit val);
    serial_in = val; sampling_strobe = 1; data_is_available = dav;
    is_parity_stage = par; data_is_valid = stp;
    step();
    sampling_strobe = 0; data_is_available = 0; is_parity_stage = 0; data_is_valid = 0;
    serial_in = $urandom_range(0, 1);
  endtask

  // Gap, ignored start-bit strobe, data bits, optional parity; returns right after the stop edge.
  task automatic send_frame(input logic [15:0] bits, input int n, input bit ps, input bit pb,
                            input bit stop, input bit rdy_stop, output logic v_before);
    step();
    strobe_bit(0, 0, 0, 0);
    step();
    for (int i = 0; i < n; i++) begin
      strobe_bit(1, 0, 0, bits[i]);
      step();
    end
    if (ps) begin
      strobe_bit(0, 1, 0, pb);
      step();
    end
    v_before = rx_valid;
    if (rdy_stop) rx_ready = 1;
    strobe_bit(0, 0, 1, stop);
    if (rdy_stop) rx_ready = 0;
  endtask

  task automatic pop_one();
    rx_ready = 1;
    step();
    rx_ready = 0;
  endtask

  typedef struct {
    logic [15:0] bits;
    int          n;
    bit          ps;
    bit          pb;
    bit          stop;
    logic [7:0]  exp_data;
    bit          exp_perr;
    bit          exp_ferr;
  } vec_t;

  vec_t tbl[8];
  logic vb;

  initial begin
    tbl[0] = '{16'h00A5, 8, 1, 0, 1, 8'hA5, 0, 0};
    tbl[1] = '{16'h00A5, 8, 1, 1, 1, 8'hA5, 1, 0};
    tbl[2] = '{16'h003C, 8, 1, 0, 0, 8'h3C, 0, 1};
    tbl[3] = '{16'h0055, 7, 1, 0, 1, 8'hAA, 0, 1};
    tbl[4] = '{16'h000F, 8, 0, 0, 1, 8'h0F, 1, 0};
    tbl[5] = '{16'h015A, 9, 1, 1, 1, 8'hAD, 0, 1};
    tbl[6] = '{16'h0000, 8, 1, 0, 1, 8'h00, 0, 0};
    tbl[7] = '{16'h00FE, 8, 1, 0, 1, 8'hFE, 1, 0};

    // Reset state
    step(); step();
    cmp("reset_state", {5'd0, rx_valid, rx_parity_err, rx_frame_err, rx_data, rx_overrun}, 16'd0);
    reset = 1;
    step();

    // Table-driven single frames with pop afterwards
    for (int i = 0; i < 8; i++) begin
      send_frame(tbl[i].bits, tbl[i].n, tbl[i].ps, tbl[i].pb, tbl[i].stop, 0, vb);
      cmp($sformatf("tbl%0d_pre", i), {15'd0, vb}, 16'd0);
      cmp($sformatf("tbl%0d_head", i),
          {5'd0, rx_valid, rx_parity_err, rx_frame_err, rx_data, rx_overrun},
          {5'd0, 1'b1, tbl[i].exp_perr, tbl[i].exp_ferr, tbl[i].exp_data, 1'b0});
      cmp($sformatf("tbl%0d_np_perr", i), {15'd0, rx_parity_err2}, 16'd0);
      check_all($sformatf("tbl%0d_model", i));
      pop_one();
      cmp($sformatf("tbl%0d_popped", i), {15'd0, rx_valid}, 16'd0);
    end

    // Overrun: four frames fill the FIFO, the fifth is dropped
    for (int k = 1; k <= 5; k++) begin
      send_frame(16'(k), 8, 1, ^(8'(k)), 1, 0, vb);
      if (k == 4) cmp("ovr_not_yet", {15'd0, rx_overrun}, 16'd0);
    end
    cmp("ovr_set", {15'd0, rx_overrun}, 16'd1);
    for (int k = 1; k <= 4; k++) begin
      cmp($sformatf("drain%0d", k), {7'd0, rx_valid, rx_data}, {7'd0, 1'b1, 8'(k)});
      pop_one();
    end
    cmp("drain_empty", {15'd0, rx_valid}, 16'd0);
    pop_one();
    cmp("pop_empty", {14'd0, rx_valid, rx_overrun}, 16'd1);
    clear_overrun = 1;
    step();
    clear_overrun = 0;
    cmp("ovr_clear", {15'd0, rx_overrun}, 16'd0);

    // Full FIFO: stop strobe coincides with a pop
    for (int k = 0; k < 4; k++) send_frame(16'(8'h10 + k), 8, 1, ^(8'(8'h10 + k)), 1, 0, vb);
    send_frame(16'h0014, 8, 1, ^(8'h14), 1, 1, vb);
    cmp("full_pop_no_ovr", {15'd0, rx_overrun}, 16'd0);
    for (int k = 1; k <= 4; k++) begin
      cmp($sformatf("full_pop_order%0d", k), {7'd0, rx_valid, rx_data},
          {7'd0, 1'b1, 8'(8'h10 + k)});
      pop_one();
    end
    cmp("full_pop_empty", {15'd0, rx_valid}, 16'd0);

    // Reset in the middle of a frame, with a frame already queued
    send_frame(16'h0077, 8, 1, ^(8'h77), 1, 0, vb);
    step();
    for (int i = 0; i < 3; i++) begin
      strobe_bit(1, 0, 0, 1);
      step();
    end
    reset = 0;
    #1;
    cmp("midreset_out", {5'd0, rx_valid, rx_parity_err, rx_frame_err, rx_data, rx_overrun}, 16'd0);
    cmp("midreset_np", {5'd0, rx_valid2, rx_parity_err2, rx_frame_err2, rx_data2, rx_overrun2},
        16'd0);
    step(); step();
    reset = 1;
    send_frame(16'h003C, 8, 1, 0, 1, 0, vb);
    cmp("after_reset", {5'd0, rx_valid, rx_parity_err, rx_frame_err, rx_data, rx_overrun},
        {5'd0, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0});
    pop_one();

    // Randomized frames against the reference model, every cycle
    rand_ctl = 1;
    chk_each = 1;
    for (int f = 0; f < 200; f++) begin
      send_frame(16'($urandom), $urandom_range(6, 10), ($urandom_range(0, 7) != 0),
                 $urandom_range(0, 1), ($urandom_range(0, 7) != 0), 0, vb);
    end
    rand_ctl = 0;
    chk_each = 0;
    rx_ready = 0;
    clear_overrun = 0;
    step();
    check_all("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
